// File: rtl/seg_scan_capture.sv
// Receive side of the 6-digit multiplexed display scan.
// Rebuilds {seg_sel,d} dwells into 24-bit frames and flags scan-integrity errors.
module seg_scan_capture #(
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned TIMEOUT_W = 12,
  parameter int unsigned ERR_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       seg_sel,
  input  logic [3:0]       d,
  output logic [23:0]      frame_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             sync_lost,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned SEL_W   = 6;
  localparam int unsigned DIG_W   = 4;
  localparam int unsigned PAIR_W  = SEL_W + DIG_W;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned SLOTS   = 5;
  localparam int unsigned FRAME_W = 24;
  localparam int unsigned STAB_W  = $clog2(SETTLE + 2);

  localparam logic [STAB_W-1:0]    STAB_CAP  = STAB_W'(SETTLE);
  localparam logic [STAB_W-1:0]    STAB_SAT  = STAB_W'(SETTLE + 1);
  localparam logic [TIMEOUT_W-1:0] STALL_MAX = '1;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(5);
  localparam logic [ERR_W-1:0]     ERR_MAX   = '1;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_e;

  state_e                         state_q, state_d;
  logic [PAIR_W-1:0]              pair_q, pair_d;
  logic [PAIR_W-1:0]              last_q, last_d;
  logic [STAB_W-1:0]              stab_q, stab_d;
  logic [IDX_W-1:0]               expect_q, expect_d;
  logic [TIMEOUT_W-1:0]           stall_q, stall_d;
  logic [SLOTS-1:0][DIG_W-1:0]    slot_q, slot_d;
  logic [FRAME_W-1:0]             frame_data_q, frame_data_d;
  logic                           frame_valid_q, frame_valid_d;
  logic                           sync_lost_q, sync_lost_d;
  logic [ERR_W-1:0]               err_cnt_q, err_cnt_d;

  logic              cap_c;
  logic              legal_c;
  logic [IDX_W-1:0]  idx_c;
  logic [SEL_W-1:0]  cap_sel_c;
  logic [DIG_W-1:0]  cap_dig_c;
  logic              err_c;
  logic              complete_c;
  logic              drop_c;

  // Input stage: one register, stability count restarts whenever the sample changes.
  always_comb begin
    pair_d = {seg_sel, d};
    stab_d = stab_q;
    if (pair_d != pair_q) begin
      stab_d = STAB_W'(1);
    end else if (stab_q != STAB_SAT) begin
      stab_d = stab_q + STAB_W'(1);
    end
  end

  // A pair that returns after a short glitch is the same dwell, so it is not captured twice.
  always_comb begin
    cap_c  = (stab_q == STAB_CAP) && (pair_q != last_q);
    last_d = cap_c ? pair_q : last_q;
  end

  // One-hot select decode; anything else is illegal.
  always_comb begin
    cap_sel_c = pair_q[PAIR_W-1:DIG_W];
    cap_dig_c = pair_q[DIG_W-1:0];
    legal_c   = 1'b1;
    idx_c     = '0;
    case (cap_sel_c)
      6'h20:   idx_c = IDX_W'(0);
      6'h10:   idx_c = IDX_W'(1);
      6'h08:   idx_c = IDX_W'(2);
      6'h04:   idx_c = IDX_W'(3);
      6'h02:   idx_c = IDX_W'(4);
      6'h01:   idx_c = IDX_W'(5);
      default: legal_c = 1'b0;
    endcase
  end

  // Sequence tracker and stall watchdog.
  always_comb begin
    state_d    = state_q;
    expect_d   = expect_q;
    stall_d    = stall_q;
    slot_d     = slot_q;
    err_c      = 1'b0;
    complete_c = 1'b0;
    case (state_q)
      HUNT: begin
        stall_d = '0;
        if (cap_c && legal_c && (idx_c == IDX_W'(0))) begin
          slot_d[0] = cap_dig_c;
          expect_d  = IDX_W'(1);
          state_d   = TRACK;
        end
      end
      TRACK: begin
        if (cap_c) begin
          stall_d = '0;
          if (legal_c && (idx_c == expect_q)) begin
            if (expect_q == LAST_IDX) begin
              complete_c = 1'b1;
              expect_d   = '0;
            end else begin
              slot_d[expect_q] = cap_dig_c;
              expect_d         = expect_q + IDX_W'(1);
            end
          end else if (legal_c && (idx_c == IDX_W'(0))) begin
            err_c     = 1'b1;
            slot_d[0] = cap_dig_c;
            expect_d  = IDX_W'(1);
          end else begin
            err_c    = 1'b1;
            state_d  = HUNT;
            expect_d = '0;
          end
        end else if (stall_q == STALL_MAX) begin
          err_c    = 1'b1;
          state_d  = HUNT;
          expect_d = '0;
          stall_d  = '0;
        end else begin
          stall_d = stall_q + TIMEOUT_W'(1);
        end
      end
      default: begin
        state_d  = HUNT;
        expect_d = '0;
        stall_d  = '0;
      end
    endcase
  end

  // Frame handoff; a completed frame with nowhere to go is dropped and counted.
  always_comb begin
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    drop_c        = 1'b0;
    if (complete_c) begin
      if (!frame_valid_q || frame_ready) begin
        frame_data_d  = {slot_q[0], slot_q[1], slot_q[2], slot_q[3], slot_q[4], cap_dig_c};
        frame_valid_d = 1'b1;
      end else begin
        drop_c = 1'b1;
      end
    end else if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end
  end

  // Error reporting: coincident error and drop count once.
  always_comb begin
    sync_lost_d = err_c;
    err_cnt_d   = err_cnt_q;
    if ((err_c || drop_c) && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      pair_q        <= '0;
      last_q        <= '0;
      stab_q        <= '0;
      expect_q      <= '0;
      stall_q       <= '0;
      slot_q        <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      sync_lost_q   <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      pair_q        <= pair_d;
      last_q        <= last_d;
      stab_q        <= stab_d;
      expect_q      <= expect_d;
      stall_q       <= stall_d;
      slot_q        <= slot_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      sync_lost_q   <= sync_lost_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign sync_lost   = sync_lost_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed self-checking bench for seg_scan_capture (SETTLE=2, TIMEOUT_W=12, ERR_W=8).
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  seg_sel;
  logic [3:0]  d;
  logic [23:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;
  logic        sync_lost;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int sl_cnt = 0;
  int fv_cnt = 0;
  int sl0, fv0, n;

  seg_scan_capture #(.SETTLE(2), .TIMEOUT_W(12), .ERR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .seg_sel    (seg_sel),
    .d          (d),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .sync_lost  (sync_lost),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  // Cycle counts of sync_lost and frame_valid high, sampled away from the active edge.
  always @(negedge clk) begin
    if (sync_lost === 1'b1) sl_cnt++;
    if (frame_valid === 1'b1) fv_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int cnt);
    repeat (cnt) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [5:0] s, input logic [3:0] v, input int cnt);
    seg_sel = s;
    d       = v;
    ticks(cnt);
  endtask

  function automatic logic [5:0] sel_of(input int i);
    logic [5:0] base;
    base = 6'h20;
    return base >> i;
  endfunction

  task automatic do_reset();
    reset   = 1'b1;
    seg_sel = '0;
    d       = '0;
    ticks(2);
    reset = 1'b0;
    ticks(1);
  endtask

  initial begin
    reset       = 1'b1;
    seg_sel     = '0;
    d           = '0;
    frame_ready = 1'b1;
    #3;
    chk("rst_data", frame_data, 24'h0);
    chk("rst_valid", frame_valid, 1'b0);
    chk("rst_sync", sync_lost, 1'b0);
    chk("rst_err", err_cnt, 8'd0);
    ticks(2);
    reset = 1'b0;
    ticks(1);

    // Clean scan, long dwell, three frames.
    sl0 = sl_cnt;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 5; i++) drive(sel_of(i), 4'(i), 1024);
      drive(6'h01, 4'd5, 2);
      chk("clean_valid_pre", frame_valid, 1'b0);
      ticks(1);
      chk("clean_valid", frame_valid, 1'b1);
      chk("clean_data", frame_data, 24'h012345);
      ticks(1);
      chk("clean_valid_post", frame_valid, 1'b0);
      ticks(1020);
    end
    chk("clean_err", err_cnt, 8'd0);
    chk("clean_sync", 32'(sl_cnt - sl0), 32'd0);

    // Scan joins mid-pass at digit2.
    do_reset();
    sl0 = sl_cnt;
    fv0 = fv_cnt;
    for (int i = 2; i < 6; i++) drive(sel_of(i), 4'(i + 7), 8);
    chk("join_no_frame", 32'(fv_cnt - fv0), 32'd0);
    chk("join_err", err_cnt, 8'd0);
    drive(6'h20, 4'd3, 8);
    drive(6'h10, 4'd1, 8);
    drive(6'h08, 4'd4, 8);
    drive(6'h04, 4'd1, 8);
    drive(6'h02, 4'd5, 8);
    drive(6'h01, 4'd9, 8);
    chk("join_frames", 32'(fv_cnt - fv0), 32'd1);
    chk("join_data", frame_data, 24'h314159);
    chk("join_sync", 32'(sl_cnt - sl0), 32'd0);

    // Back-pressure across two frames: second is dropped.
    do_reset();
    frame_ready = 1'b0;
    sl0 = sl_cnt;
    for (int i = 0; i < 6; i++) drive(sel_of(i), 4'(9 - i), 8);
    for (int i = 0; i < 6; i++) drive(sel_of(i), 4'(i + 1), 8);
    chk("bp_data", frame_data, 24'h987654);
    chk("bp_valid", frame_valid, 1'b1);
    chk("bp_err", err_cnt, 8'd1);
    chk("bp_sync", 32'(sl_cnt - sl0), 32'd0);
    frame_ready = 1'b1;
    ticks(1);
    chk("bp_accept", frame_valid, 1'b0);
    chk("bp_data_hold", frame_data, 24'h987654);

    // Out-of-order digit.
    do_reset();
    sl0 = sl_cnt;
    fv0 = fv_cnt;
    drive(6'h20, 4'd1, 8);
    drive(6'h10, 4'd2, 8);
    drive(6'h08, 4'd3, 8);
    drive(6'h02, 4'd5, 2);
    chk("seq_sync_pre", sync_lost, 1'b0);
    ticks(1);
    chk("seq_sync", sync_lost, 1'b1);
    ticks(1);
    chk("seq_sync_post", sync_lost, 1'b0);
    chk("seq_err", err_cnt, 8'd1);
    ticks(4);
    drive(6'h10, 4'd2, 8);
    chk("seq_hunt_err", err_cnt, 8'd1);
    chk("seq_pulses", 32'(sl_cnt - sl0), 32'd1);
    chk("seq_no_frame", 32'(fv_cnt - fv0), 32'd0);

    // Short glitch ignored, held illegal select flagged.
    do_reset();
    sl0 = sl_cnt;
    fv0 = fv_cnt;
    drive(6'h20, 4'd1, 8);
    drive(6'h10, 4'd2, 4);
    drive(6'h30, 4'd2, 1);
    drive(6'h10, 4'd2, 4);
    for (int i = 2; i < 6; i++) drive(sel_of(i), 4'(i + 1), 8);
    chk("gl_err", err_cnt, 8'd0);
    chk("gl_data", frame_data, 24'h123456);
    chk("gl_frames", 32'(fv_cnt - fv0), 32'd1);
    drive(6'h20, 4'd7, 8);
    drive(6'h30, 4'd7, 4);
    chk("ill_err", err_cnt, 8'd1);
    chk("ill_pulses", 32'(sl_cnt - sl0), 32'd1);
    drive(6'h10, 4'd8, 8);
    chk("ill_hunt_err", err_cnt, 8'd1);

    // Stalled scan after digit2.
    do_reset();
    drive(6'h20, 4'd1, 8);
    drive(6'h10, 4'd2, 8);
    seg_sel = 6'h08;
    d       = 4'd3;
    n       = 0;
    while (sync_lost !== 1'b1 && n < 5000) begin
      ticks(1);
      n++;
    end
    chk("stall_seen", sync_lost, 1'b1);
    chk("stall_window", (n >= 4097 && n <= 4101), 1'b1);
    chk("stall_err", err_cnt, 8'd1);
    ticks(1);
    chk("stall_sync_post", sync_lost, 1'b0);
    ticks(50);
    chk("stall_hunt_err", err_cnt, 8'd1);

    // Reset in the middle of a frame with a held frame pending.
    frame_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive(sel_of(i), 4'(10 + i), 8);
    chk("mid_valid", frame_valid, 1'b1);
    chk("mid_data", frame_data, 24'habcdef);
    drive(6'h20, 4'd1, 8);
    drive(6'h10, 4'd2, 3);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_data", frame_data, 24'h0);
    chk("mid_rst_valid", frame_valid, 1'b0);
    chk("mid_rst_err", err_cnt, 8'd0);
    chk("mid_rst_sync", sync_lost, 1'b0);
    ticks(2);
    reset       = 1'b0;
    frame_ready = 1'b1;
    sl0 = sl_cnt;
    fv0 = fv_cnt;
    for (int i = 1; i < 6; i++) drive(sel_of(i), 4'd15, 8);
    for (int i = 0; i < 6; i++) drive(sel_of(i), 4'(6 - i), 8);
    chk("post_data", frame_data, 24'h654321);
    chk("post_frames", 32'(fv_cnt - fv0), 32'd1);
    chk("post_err", err_cnt, 8'd0);
    chk("post_sync", 32'(sl_cnt - sl0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
